eth_rx_buf_ctrl: RTL and testbench

//  Frame-slot controller for the widening dual-port RX buffer: 9b addr, 64b write port B; 11b addr, 16b read port A.

---
 rtl/eth_rx_buf_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_eth_rx_buf_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_buf_ctrl.sv
// eth_rx_buf_ctrl: frame-slot controller for a widening dual-port RX buffer.
// Port B (9b addr, 64b data) receives AXI-Stream RX beats into a ring of
// fixed-size slots. Port A (11b addr, 16b data) serves host halfword reads
// from the head slot. Committed frames are published with their byte length.
// Optional build macro ETH_RX_ERR_DROP_EN: a frame whose last beat carries
// tuser=1 is discarded instead of committed.
module eth_rx_buf_ctrl #(
  parameter int SLOT_W    = 1,
  parameter int MAX_WORDS = 192
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [63:0]        s_axis_tdata_i,
  input  logic [7:0]         s_axis_tkeep_i,
  input  logic               s_axis_tlast_i,
  input  logic               s_axis_tuser_i,
  input  logic               s_axis_tvalid_i,
  output logic               s_axis_tready_o,
  output logic [8:0]         mem_addrb_o,
  output logic [63:0]        mem_dinb_o,
  output logic [1:0]         mem_web_o,
  output logic               mem_enb_o,
  output logic [10:0]        mem_addra_o,
  output logic               mem_ena_o,
  input  logic [15:0]        mem_douta_i,
  output logic               rx_avail_o,
  output logic [10:0]        rx_len_o,
  input  logic               rx_release_i,
  input  logic               rd_en_i,
  input  logic [10-SLOT_W:0] rd_offs_i,
  output logic [15:0]        rd_data_o,
  output logic               rd_valid_o,
  output logic [15:0]        drop_cnt_o
);

  localparam int NSLOT  = 2 ** SLOT_W;
  localparam int WORD_W = 9 - SLOT_W;   // word index within a slot
  localparam int WCNT_W = WORD_W + 1;   // one extra bit so MAX_WORDS always fits

  localparam logic [SLOT_W:0]   PTR_ONE  = 1;
  localparam logic [SLOT_W:0]   FULL_CNT = (SLOT_W + 1)'(NSLOT);
  localparam logic [WCNT_W-1:0] WC_ONE   = 1;
  localparam logic [WCNT_W-1:0] WC_MAX   = WCNT_W'(MAX_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} state_e;

  state_e              state_q, state_d;
  logic [SLOT_W:0]     wr_ptr_q, wr_ptr_d;
  logic [SLOT_W:0]     rd_ptr_q, rd_ptr_d;
  logic [SLOT_W:0]     count_q, count_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic [10:0]         len_q [NSLOT];
  logic                rd_valid_q;

  logic                wr_en, commit, drop_inc, release_ok, avail;
  logic [WORD_W-1:0]   wr_word;
  logic [SLOT_W-1:0]   wr_slot, rd_slot;
  logic [3:0]          keep_bytes;
  logic [10:0]         commit_len;

  assign wr_slot    = wr_ptr_q[SLOT_W-1:0];
  assign rd_slot    = rd_ptr_q[SLOT_W-1:0];
  assign avail      = (count_q != '0);
  assign release_ok = rx_release_i && avail;
  // tkeep is contiguous from bit 0, so its popcount is the byte count of the beat
  assign keep_bytes = 4'($countones(s_axis_tkeep_i));
  assign commit_len = (11'(word_cnt_q) << 3) + 11'(keep_bytes);

`ifndef ETH_RX_ERR_DROP_EN
  logic unused_tuser;
  assign unused_tuser = s_axis_tuser_i;
`endif

  // Frame FSM: decide per beat whether to write, commit or drop
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    wr_en      = 1'b0;
    commit     = 1'b0;
    drop_inc   = 1'b0;
    wr_word    = word_cnt_q[WORD_W-1:0];
    if (s_axis_tvalid_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (count_q == FULL_CNT) begin
            drop_inc = 1'b1;
            state_d  = s_axis_tlast_i ? S_IDLE : S_DROP;
          end else begin
            wr_en      = 1'b1;
            wr_word    = '0;
            word_cnt_d = WC_ONE;
            state_d    = S_WRITE;
          end
        end
        S_WRITE: begin
          if (word_cnt_q == WC_MAX) begin
            drop_inc   = 1'b1;
            word_cnt_d = '0;
            state_d    = s_axis_tlast_i ? S_IDLE : S_DROP;
          end else begin
            wr_en      = 1'b1;
            word_cnt_d = word_cnt_q + WC_ONE;
          end
        end
        S_DROP: begin
          if (s_axis_tlast_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      // A written last beat ends the frame: publish it (or discard on error)
      if (wr_en && s_axis_tlast_i) begin
        word_cnt_d = '0;
        state_d    = S_IDLE;
`ifdef ETH_RX_ERR_DROP_EN
        if (s_axis_tuser_i) drop_inc = 1'b1;
        else                commit   = 1'b1;
`else
        commit = 1'b1;
`endif
      end
    end
  end

  // Ring bookkeeping: pointers, occupancy and saturating drop counter
  always_comb begin
    wr_ptr_d   = commit     ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = release_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d    = count_q;
    if (commit && !release_ok)      count_d = count_q + PTR_ONE;
    else if (!commit && release_ok) count_d = count_q - PTR_ONE;
    drop_cnt_d = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_cnt_q <= '0;
      drop_cnt_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      rd_valid_q <= mem_ena_o;
    end
  end

  // Per-slot frame length, written on commit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: this small table is reset so rx_len never exposes X; a large RAM would not be.
    if (!rst_ni) begin
      for (int i = 0; i < NSLOT; i++) len_q[i] <= '0;
    end else if (commit) begin
      len_q[wr_slot] <= commit_len;
    end
  end

  assign s_axis_tready_o = 1'b1;
  assign mem_addrb_o     = {wr_slot, wr_word};
  assign mem_dinb_o      = s_axis_tdata_i;
  assign mem_web_o       = {2{wr_en}};
  assign mem_enb_o       = wr_en;
  assign mem_addra_o     = {rd_slot, rd_offs_i};
  assign mem_ena_o       = rd_en_i && avail;
  assign rd_data_o       = mem_douta_i;
  assign rd_valid_o      = rd_valid_q;
  assign rx_avail_o      = avail;
  assign rx_len_o        = avail ? len_q[rd_slot] : 11'd0;
  assign drop_cnt_o      = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_buf_ctrl.sv
// Testbench for eth_rx_buf_ctrl: frame-level reference model (queue of
// committed frames, expected buffer image) compared every cycle, plus
// directed scenarios with hand-computed expectations, then random traffic.
module tb_eth_rx_buf_ctrl;

  localparam int NSLOT     = 2;
  localparam int MAX_WORDS = 192;
  localparam int DEPTH     = 256;   // 64b words per slot
  localparam int ACT_NONE  = 0;
  localparam int ACT_WRITE = 1;
  localparam int ACT_DROP  = 2;
`ifdef ETH_RX_ERR_DROP_EN
  localparam bit ERR_DROP = 1'b1;
`else
  localparam bit ERR_DROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast, s_axis_tuser, s_axis_tvalid, s_axis_tready;
  logic [8:0]  mem_addrb;
  logic [63:0] mem_dinb;
  logic [1:0]  mem_web;
  logic        mem_enb;
  logic [10:0] mem_addra;
  logic        mem_ena;
  logic [15:0] mem_douta;
  logic        rx_avail;
  logic [10:0] rx_len;
  logic        rx_release, rd_en;
  logic [9:0]  rd_offs;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  eth_rx_buf_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_axis_tdata_i(s_axis_tdata), .s_axis_tkeep_i(s_axis_tkeep),
    .s_axis_tlast_i(s_axis_tlast), .s_axis_tuser_i(s_axis_tuser),
    .s_axis_tvalid_i(s_axis_tvalid), .s_axis_tready_o(s_axis_tready),
    .mem_addrb_o(mem_addrb), .mem_dinb_o(mem_dinb), .mem_web_o(mem_web),
    .mem_enb_o(mem_enb), .mem_addra_o(mem_addra), .mem_ena_o(mem_ena),
    .mem_douta_i(mem_douta), .rx_avail_o(rx_avail), .rx_len_o(rx_len),
    .rx_release_i(rx_release), .rd_en_i(rd_en), .rd_offs_i(rd_offs),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .drop_cnt_o(drop_cnt)
  );

  // Dual-port buffer: 512x64 write side, 2048x16 read side, 1-cycle read latency
  logic [63:0] ram [0:511];
  logic [15:0] douta_q = 16'h0;
  assign mem_douta = douta_q;
  initial for (int i = 0; i < 512; i++) ram[i] = 64'h0;
  always @(posedge clk) begin
    if (mem_enb && mem_web[0]) ram[mem_addrb][31:0]  <= mem_dinb[31:0];
    if (mem_enb && mem_web[1]) ram[mem_addrb][63:32] <= mem_dinb[63:32];
    if (mem_ena) douta_q <= ram[mem_addra[10:2]][mem_addra[1:0]*16 +: 16];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { int len; int slot; } frame_t;
  frame_t      fq[$];          // committed frames, head first
  logic [63:0] mmem [0:511];   // expected buffer image
  bit          m_in_frame, m_dropping;
  int          m_beats, m_wr_idx, m_drop;
  bit          pend_ena, exp_rd_valid;
  logic [15:0] pend_data, exp_rd_data;

  function automatic int popcnt(input logic [7:0] k);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(k[i]);
    return c;
  endfunction

  function automatic int decide();
    if (!s_axis_tvalid || m_dropping) return ACT_NONE;
    if (!m_in_frame) return (fq.size() == NSLOT) ? ACT_DROP : ACT_WRITE;
    return (m_beats == MAX_WORDS) ? ACT_DROP : ACT_WRITE;
  endfunction

  function automatic int wr_addr();
    return (m_wr_idx % NSLOT) * DEPTH + (m_in_frame ? m_beats : 0);
  endfunction

  task automatic model_step();
    int act, beat;
    bit had;
    if (!rst_n) begin
      fq.delete();
      for (int i = 0; i < 512; i++) mmem[i] = 64'h0;
      m_in_frame = 0; m_dropping = 0; m_beats = 0; m_wr_idx = 0; m_drop = 0;
      pend_ena = 0; exp_rd_valid = 0; pend_data = '0; exp_rd_data = '0;
      return;
    end
    had = fq.size() > 0;
    act = decide();
    exp_rd_valid = pend_ena;
    exp_rd_data  = pend_data;
    if (act == ACT_WRITE) begin
      beat = m_in_frame ? m_beats : 0;
      mmem[wr_addr()] = s_axis_tdata;
      if (s_axis_tlast) begin
        m_in_frame = 0; m_beats = 0;
        if (ERR_DROP && s_axis_tuser) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          fq.push_back('{len: beat * 8 + popcnt(s_axis_tkeep), slot: m_wr_idx % NSLOT});
          m_wr_idx++;
        end
      end else begin
        m_in_frame = 1; m_beats = beat + 1;
      end
    end else if (act == ACT_DROP) begin
      if (m_drop < 65535) m_drop++;
      m_in_frame = 0; m_beats = 0;
      m_dropping = !s_axis_tlast;
    end else if (s_axis_tvalid && m_dropping && s_axis_tlast) begin
      m_dropping = 0;
    end
    if (rx_release && had) void'(fq.pop_front());
  endtask

  task automatic do_check();
    int act, a, el;
    bit ea;
    ea = fq.size() > 0;
    el = ea ? fq[0].len : 0;
    check("tready", s_axis_tready, 1);
    check("rx_avail", rx_avail, ea);
    check("rx_len", rx_len, el);
    check("drop_cnt", drop_cnt, m_drop);
    check("rd_valid", rd_valid, exp_rd_valid);
    if (exp_rd_valid) check("rd_data", rd_data, exp_rd_data);
    act = decide();
    check("mem_enb", mem_enb, act == ACT_WRITE);
    check("mem_web", mem_web, (act == ACT_WRITE) ? 2'b11 : 2'b00);
    if (act == ACT_WRITE) begin
      check("mem_addrb", mem_addrb, wr_addr());
      check("mem_dinb", mem_dinb, s_axis_tdata);
    end
    pend_ena = rd_en && ea;
    check("mem_ena", mem_ena, pend_ena);
    if (pend_ena) begin
      a = fq[0].slot * 1024 + int'(rd_offs);
      check("mem_addra", mem_addra, a);
      pend_data = mmem[a >> 2][(a % 4) * 16 +: 16];
    end
  endtask

  initial forever begin @(posedge clk); model_step(); end
  initial forever begin @(negedge clk); if (rst_n) do_check(); end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input logic [63:0] d, input logic [7:0] k, input bit l,
                     input bit u, input bit rel, input bit rd, input logic [9:0] offs);
    s_axis_tvalid = v; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l;
    s_axis_tuser = u; rx_release = rel; rd_en = rd; rd_offs = offs;
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] mkbeat(input int i);
    logic [63:0] d;
    for (int b = 0; b < 8; b++) d[8*b +: 8] = 8'(8 * i + b);
    return d;
  endfunction

  task automatic frame(input int n, input logic [7:0] last_keep, input bit user);
    for (int i = 0; i < n; i++)
      cyc(1, {$urandom, $urandom}, (i == n - 1) ? last_keep : 8'hFF, i == n - 1,
          user && (i == n - 1), 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 0;
    s_axis_tuser = 0; rx_release = 0; rd_en = 0; rd_offs = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_avail", rx_avail, 0);
    check("rst_len", rx_len, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_tready", s_axis_tready, 1);
    check("rst_enb", mem_enb, 0);
    check("rst_web", mem_web, 0);
    check("rst_drop", drop_cnt, 0);
    rst_n = 1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // 8-beat frame, last keep 0x0F -> 60 bytes
    for (int i = 0; i < 8; i++) cyc(1, mkbeat(i), (i == 7) ? 8'h0F : 8'hFF, i == 7, 0, 0, 0, 0);
    check("t1_avail", rx_avail, 1);
    check("t1_len", rx_len, 60);

    // halfword reads of beat 0
    cyc(0, 0, 0, 0, 0, 0, 1, 10'd0);
    check("t2_valid0", rd_valid, 1);
    check("t2_data0", rd_data, 16'h0100);
    cyc(0, 0, 0, 0, 0, 0, 1, 10'd1);
    check("t2_data1", rd_data, 16'h0302);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);

    // three 1-beat frames into two slots: third dropped
    repeat (3) frame(1, 8'hFF, 0);
    check("t3_drop", drop_cnt, 1);
    check("t3_avail", rx_avail, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    check("t3_empty", rx_avail, 0);

    // 193 beats overflows; next frame reuses the slot
    frame(193, 8'hFF, 0);
    check("t4_drop", drop_cnt, 2);
    check("t4_avail", rx_avail, 0);
    frame(1, 8'h1F, 0);
    check("t4_len", rx_len, 5);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    frame(192, 8'hFF, 0);
    check("t4_maxlen", rx_len, 1536);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);

    // commit and release in the same cycle
    frame(1, 8'hFF, 0);
    cyc(1, 64'h1234, 8'h03, 1, 0, 1, 0, 0);
    check("t5_avail", rx_avail, 1);
    check("t5_len", rx_len, 2);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    check("t5_rd", rd_data, 16'h1234);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);

    // errored frame
    frame(1, 8'hFF, 1);
`ifdef ETH_RX_ERR_DROP_EN
    check("t6_avail", rx_avail, 0);
    check("t6_drop", drop_cnt, 3);
`else
    check("t6_avail", rx_avail, 1);
    check("t6_len", rx_len, 8);
    check("t6_drop", drop_cnt, 2);
`endif
    cyc(0, 0, 0, 0, 0, 1, 0, 0);

    // random traffic
    for (int f = 0; f < 120; f++) begin
      int n, relmode, b;
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(185, 200)) : int'($urandom_range(1, 24));
      relmode = $urandom_range(0, 2);
      b = 0;
      while (b < n) begin
        bit v, l;
        logic [7:0] k;
        v = $urandom_range(0, 3) != 0;
        l = v && (b == n - 1);
        k = l ? (8'hFF >> $urandom_range(0, 7)) : 8'hFF;
        cyc(v, {$urandom, $urandom}, k, l, l && ($urandom_range(0, 4) == 0),
            (relmode != 0) && ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
            10'($urandom));
        if (v) b++;
      end
    end
    repeat (4) cyc(0, 0, 0, 0, 0, 1, 1, 10'($urandom));
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
